// File: rtl/router_out_arbiter.sv
// Round-robin output-port arbiter for the 16x16 router: grants one input channel per frame,
// holds it until the owner drops its request or the hold watchdog expires.
module router_out_arbiter #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 1024,
  parameter int CW       = 11
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] owner,
  output logic           busy_n,
  output logic           timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam bit            WD_EN     = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] owner_d;
  logic           busy_n_d;
  logic           timeout_d;

  logic           win_valid;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   probe;

  // Rotating priority search: scan downwards so the candidate closest to rr_ptr is written last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      probe = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(N)) probe = probe - (IDW+1)'(N);
      if (req[probe[IDW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = probe[IDW-1:0];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant;
    owner_d    = owner;
    busy_n_d   = busy_n;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (win_valid) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          busy_n_d         = 1'b0;
          hold_cnt_d       = '0;
        end else begin
          state_d  = IDLE;
          grant_d  = '0;
          busy_n_d = 1'b1;
        end
      end

      BUSY: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + CW'(1);
        // A dropped request takes precedence, so a frame ending on the watchdog cycle is not a timeout.
        if (!req[owner] || (WD_EN && hold_cnt_q == HOLD_LAST)) begin
          state_d   = RELEASE;
          grant_d   = '0;
          busy_n_d  = 1'b0;
          rr_ptr_d  = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
          timeout_d = req[owner];
        end
      end

      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        busy_n_d = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      grant      <= '0;
      owner      <= '0;
      busy_n     <= 1'b1;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant      <= grant_d;
      owner      <= owner_d;
      busy_n     <= busy_n_d;
      timeout    <= timeout_d;
    end
  end

endmodule
